// File: rtl/cascade_pkg.sv
// Shared types and trained stage thresholds for the Viola-Jones cascade evaluator.
// Thresholds are the frontal-face cascade stage thresholds rounded to nearest at Q.12.
package cascade_pkg;

    localparam int FRAC_BITS  = 12;
    localparam int MAX_STAGES = 64;
    localparam int THRESH_W   = 24;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        CMP,
        DONE
    } stage_state_t;

    localparam logic signed [THRESH_W-1:0] STAGE_THRESH_Q [MAX_STAGES] = '{
        24'sd3370,   24'sd28494,  24'sd38906,  24'sd75420,
        24'sd62768,  24'sd86060,  24'sd97971,  24'sd100464,
        24'sd111220, 24'sd141534, 24'sd160184, 24'sd207301,
        24'sd223724, 24'sd205495, 24'sd273077, 24'sd277295,
        24'sd283566, 24'sd324604, 24'sd359203, 24'sd369678,
        24'sd429053, 24'sd433197,
        24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0,
        24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0,
        24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0,
        24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0,
        24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0, 24'sd0,
        24'sd0, 24'sd0
    };

endpackage

// File: rtl/cascade_stage_eval_rom.sv
// Registered threshold lookup: the value for 'stage' appears one clock after 'en'.
module stage_thresh_rom
    import cascade_pkg::*;
#(
    parameter int NUM_STAGES = 22,
    parameter int ACC_W      = 24,
    parameter int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [STAGE_W-1:0]      stage,
    output logic signed [ACC_W-1:0] thresh
);

    logic [5:0]                   addr;
    logic signed [THRESH_W-1:0]   entry;

    assign addr  = 6'(stage);
    assign entry = (int'(addr) < NUM_STAGES) ? STAGE_THRESH_Q[addr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh <= '0;
        end else if (en) begin
            thresh <= ACC_W'(entry);
        end
    end

endmodule

// File: rtl/cascade_stage_eval.sv
// Sequential cascade stage evaluator: accumulates weak-classifier votes per stage
// and rejects the window early or declares a face once the last stage passes.
module cascade_stage_eval
    import cascade_pkg::*;
#(
    parameter int NUM_STAGES = 22,
    parameter int FRAC_BITS  = cascade_pkg::FRAC_BITS,
    parameter int VOTE_W     = 16,
    parameter int ACC_W      = 24,
    parameter int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     vote_valid,
    output logic                     vote_ready,
    input  logic signed [VOTE_W-1:0] vote_data,
    input  logic                     vote_last,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_face,
    output logic [STAGE_W-1:0]       res_stage,
    output logic [STAGE_W-1:0]       cur_stage
);

    if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES || FRAC_BITS >= ACC_W || VOTE_W > ACC_W) begin : g_bad_cfg
        $error("cascade_stage_eval: unsupported parameter combination");
    end

    localparam logic [STAGE_W-1:0]      LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

    stage_state_t             state;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    sum_wide;
    logic signed [ACC_W-1:0]  sum_sat;
    logic signed [ACC_W-1:0]  thresh;
    logic                     pass;

    stage_thresh_rom #(
        .NUM_STAGES(NUM_STAGES),
        .ACC_W     (ACC_W),
        .STAGE_W   (STAGE_W)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ACCUM),
        .stage (cur_stage),
        .thresh(thresh)
    );

    // One extra bit of headroom exposes overflow; clamp instead of wrapping.
    always_comb begin
        sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(vote_data);
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_W-1:0];
        end
    end

    assign pass = (acc >= thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            vote_ready <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_face   <= 1'b0;
            res_stage  <= '0;
            cur_stage  <= '0;
        end else if (abort) begin
            state      <= IDLE;
            acc        <= '0;
            cur_stage  <= '0;
            vote_ready <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= '0;
                        cur_stage  <= '0;
                        busy       <= 1'b1;
                        vote_ready <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (vote_valid && vote_ready) begin
                        acc <= sum_sat;
                        if (vote_last) begin
                            vote_ready <= 1'b0;
                            state      <= CMP;
                        end
                    end
                end
                CMP: begin
                    if (!pass || cur_stage == LAST_STAGE) begin
                        res_face  <= pass;
                        res_stage <= cur_stage;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cur_stage  <= cur_stage + STAGE_W'(1);
                        acc        <= '0;
                        vote_ready <= 1'b1;
                        state      <= ACCUM;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cascade_stage_eval.sv
// Directed bench for cascade_stage_eval: a default 22-stage instance plus a
// 2-stage, 16-bit-accumulator instance for the full-pass and saturation cases.
module tb_cascade_stage_eval;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic              a_start, a_abort, a_vote_valid, a_vote_last, a_res_ready;
    logic signed [15:0] a_vote_data;
    logic              a_vote_ready, a_busy, a_res_valid, a_res_face;
    logic [4:0]        a_res_stage, a_cur_stage;

    logic              b_start, b_abort, b_vote_valid, b_vote_last, b_res_ready;
    logic signed [15:0] b_vote_data;
    logic              b_vote_ready, b_busy, b_res_valid, b_res_face;
    logic [0:0]        b_res_stage, b_cur_stage;

    int checks = 0;
    int errors = 0;
    int cnt;
    int v;

    cascade_stage_eval dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (a_start),
        .abort     (a_abort),
        .vote_valid(a_vote_valid),
        .vote_ready(a_vote_ready),
        .vote_data (a_vote_data),
        .vote_last (a_vote_last),
        .busy      (a_busy),
        .res_valid (a_res_valid),
        .res_ready (a_res_ready),
        .res_face  (a_res_face),
        .res_stage (a_res_stage),
        .cur_stage (a_cur_stage)
    );

    cascade_stage_eval #(
        .NUM_STAGES(2),
        .FRAC_BITS (4),
        .ACC_W     (16)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (b_start),
        .abort     (b_abort),
        .vote_valid(b_vote_valid),
        .vote_ready(b_vote_ready),
        .vote_data (b_vote_data),
        .vote_last (b_vote_last),
        .busy      (b_busy),
        .res_valid (b_res_valid),
        .res_ready (b_res_ready),
        .res_face  (b_res_face),
        .res_stage (b_res_stage),
        .cur_stage (b_cur_stage)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents one vote for a single cycle on the selected instance.
    task automatic applyStimulus(input bit on_b, input int data, input logic last);
        if (on_b) begin
            b_vote_valid = 1'b1;
            b_vote_data  = 16'(data);
            b_vote_last  = last;
        end else begin
            a_vote_valid = 1'b1;
            a_vote_data  = 16'(data);
            a_vote_last  = last;
        end
        @(negedge clk);
        a_vote_valid = 1'b0;
        a_vote_last  = 1'b0;
        b_vote_valid = 1'b0;
        b_vote_last  = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        a_start      = 1'b0; a_abort = 1'b0; a_vote_valid = 1'b0; a_vote_last = 1'b0;
        a_res_ready  = 1'b0; a_vote_data = '0;
        b_start      = 1'b0; b_abort = 1'b0; b_vote_valid = 1'b0; b_vote_last = 1'b0;
        b_res_ready  = 1'b0; b_vote_data = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_busy",       32'(a_busy),       0);
        checkOutput("rst_vote_ready", 32'(a_vote_ready), 0);
        checkOutput("rst_res_valid",  32'(a_res_valid),  0);
        checkOutput("rst_res_face",   32'(a_res_face),   0);
        checkOutput("rst_res_stage",  32'(a_res_stage),  0);
        checkOutput("rst_cur_stage",  32'(a_cur_stage),  0);
        checkOutput("rst_b_busy",     32'(b_busy),       0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] stage-0 reject");
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        checkOutput("t1_busy",       32'(a_busy),       1);
        checkOutput("t1_ready",      32'(a_vote_ready), 1);
        checkOutput("t1_cur_stage",  32'(a_cur_stage),  0);
        applyStimulus(0, 1000, 1'b0);
        applyStimulus(0, 2000, 1'b1);
        checkOutput("t1_ready_drop", 32'(a_vote_ready), 0);
        checkOutput("t1_valid_cmp",  32'(a_res_valid),  0);
        @(negedge clk);
        checkOutput("t1_res_valid",  32'(a_res_valid),  1);
        checkOutput("t1_res_face",   32'(a_res_face),   0);
        checkOutput("t1_res_stage",  32'(a_res_stage),  0);
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        checkOutput("t1_done_start_valid", 32'(a_res_valid), 1);
        checkOutput("t1_done_start_busy",  32'(a_busy),      1);
        a_res_ready = 1'b1; @(negedge clk); a_res_ready = 1'b0;
        checkOutput("t1_release_valid", 32'(a_res_valid), 0);
        checkOutput("t1_release_busy",  32'(a_busy),      0);

        $display("[TB] exact threshold pass");
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        applyStimulus(0, 3000, 1'b0);
        applyStimulus(0, 370, 1'b1);
        @(negedge clk);
        checkOutput("t2_cur_stage", 32'(a_cur_stage),  1);
        checkOutput("t2_ready",     32'(a_vote_ready), 1);
        checkOutput("t2_no_result", 32'(a_res_valid),  0);
        applyStimulus(0, 28000, 1'b0);
        applyStimulus(0, 493, 1'b1);
        @(negedge clk);
        checkOutput("t2_res_valid", 32'(a_res_valid), 1);
        checkOutput("t2_res_face",  32'(a_res_face),  0);
        checkOutput("t2_res_stage", 32'(a_res_stage), 1);
        a_res_ready = 1'b1; @(negedge clk); a_res_ready = 1'b0;

        $display("[TB] abort priority");
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        applyStimulus(0, 3370, 1'b1);  @(negedge clk);
        applyStimulus(0, 28494, 1'b1); @(negedge clk);
        applyStimulus(0, 30000, 1'b0);
        applyStimulus(0, 8906, 1'b1);  @(negedge clk);
        checkOutput("t3_cur_stage3", 32'(a_cur_stage), 3);
        applyStimulus(0, 10000, 1'b0);
        a_abort = 1'b1; a_vote_valid = 1'b1; a_vote_data = 16'sd30000; a_vote_last = 1'b1;
        @(negedge clk);
        a_abort = 1'b0; a_vote_valid = 1'b0; a_vote_last = 1'b0;
        checkOutput("t3_abort_busy",  32'(a_busy),       0);
        checkOutput("t3_abort_ready", 32'(a_vote_ready), 0);
        checkOutput("t3_abort_stage", 32'(a_cur_stage),  0);
        checkOutput("t3_abort_valid", 32'(a_res_valid),  0);
        a_start = 1'b1; a_abort = 1'b1; @(negedge clk); a_start = 1'b0; a_abort = 1'b0;
        checkOutput("t3_start_abort_busy",  32'(a_busy),       0);
        checkOutput("t3_start_abort_ready", 32'(a_vote_ready), 0);
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        checkOutput("t3_restart_stage", 32'(a_cur_stage), 0);
        applyStimulus(0, 3369, 1'b1);
        @(negedge clk);
        checkOutput("t3_restart_valid", 32'(a_res_valid), 1);
        checkOutput("t3_restart_face",  32'(a_res_face),  0);
        checkOutput("t3_restart_stage", 32'(a_res_stage), 0);
        a_res_ready = 1'b1; @(negedge clk); a_res_ready = 1'b0;

        $display("[TB] handshake gaps");
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 1));
            a_vote_valid = v[0]; a_vote_data = 16'sd100; a_vote_last = 1'b0;
            if (v != 0) cnt++;
            @(negedge clk);
        end
        applyStimulus(0, 3370 - 100 * cnt, 1'b1);
        a_vote_valid = 1'b1; a_vote_data = 16'sd1000; @(negedge clk); a_vote_valid = 1'b0;
        checkOutput("t4_stage0_pass", 32'(a_cur_stage), 1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(0, 1));
            a_vote_valid = v[0]; a_vote_data = 16'sd1000; a_vote_last = 1'b0;
            if (v != 0) cnt++;
            @(negedge clk);
        end
        applyStimulus(0, 28493 - 1000 * cnt, 1'b1);
        @(negedge clk);
        checkOutput("t4_res_valid", 32'(a_res_valid), 1);
        checkOutput("t4_res_face",  32'(a_res_face),  0);
        checkOutput("t4_res_stage", 32'(a_res_stage), 1);
        for (int k = 0; k < 4; k++) begin
            a_start = (k == 1);
            @(negedge clk);
            checkOutput("t4_hold_valid", 32'(a_res_valid), 1);
            checkOutput("t4_hold_stage", 32'(a_res_stage), 1);
        end
        a_start = 1'b0;
        a_res_ready = 1'b1; @(negedge clk); a_res_ready = 1'b0;
        checkOutput("t4_release_busy", 32'(a_busy), 0);

        $display("[TB] two-stage full pass");
        b_start = 1'b1; @(negedge clk); b_start = 1'b0;
        applyStimulus(1, 2000, 1'b0);
        applyStimulus(1, 2000, 1'b1);
        @(negedge clk);
        checkOutput("t5_cur_stage", 32'(b_cur_stage), 1);
        applyStimulus(1, 15000, 1'b0);
        applyStimulus(1, 15000, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checkOutput("t5_hold_valid", 32'(b_res_valid), 1);
            checkOutput("t5_hold_face",  32'(b_res_face),  1);
            checkOutput("t5_hold_stage", 32'(b_res_stage), 1);
            @(negedge clk);
        end
        b_res_ready = 1'b1; @(negedge clk); b_res_ready = 1'b0;
        checkOutput("t5_release_busy", 32'(b_busy), 0);

        $display("[TB] saturation");
        b_start = 1'b1; @(negedge clk); b_start = 1'b0;
        applyStimulus(1, 32767, 1'b0);
        applyStimulus(1, 32767, 1'b0);
        applyStimulus(1, -29397, 1'b1);
        @(negedge clk);
        checkOutput("t6_pos_sat_pass",  32'(b_cur_stage), 1);
        checkOutput("t6_pos_sat_valid", 32'(b_res_valid), 0);
        applyStimulus(1, -32768, 1'b0);
        applyStimulus(1, -32768, 1'b0);
        applyStimulus(1, 32767, 1'b1);
        @(negedge clk);
        checkOutput("t6_neg_sat_valid", 32'(b_res_valid), 1);
        checkOutput("t6_neg_sat_face",  32'(b_res_face),  0);
        checkOutput("t6_neg_sat_stage", 32'(b_res_stage), 1);
        b_res_ready = 1'b1; @(negedge clk); b_res_ready = 1'b0;

        $display("[TB] reset mid-window");
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        applyStimulus(0, 3370, 1'b1);
        @(negedge clk);
        applyStimulus(0, 500, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_busy",  32'(a_busy),       0);
        checkOutput("t7_rst_ready", 32'(a_vote_ready), 0);
        checkOutput("t7_rst_stage", 32'(a_cur_stage),  0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cascade_stage_eval.md
Name: cascade_stage_eval

Overview:
- Sequential Viola-Jones cascade stage evaluator for the face-detection pipeline.
- Consumes a stream of weak-classifier votes for one candidate window and accumulates them per stage.
- At the end of each stage, compares the accumulated sum against that stage's fixed-point threshold, read from an internal ROM.
- Either rejects the window early or advances to the next stage; declares a face after the last stage passes.

Parameters:
- NUM_STAGES, 22: number of cascade stages; valid range 1..64.
- FRAC_BITS, 12: fractional bits of all vote, sum and threshold values (signed Qm.FRAC_BITS).
- VOTE_W, 16: signed width of one weak-classifier vote.
- ACC_W, 24: signed width of the stage accumulator and thresholds.
- STAGE_W, $clog2(NUM_STAGES): width of stage indices.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: begin a new window at stage 0; accepted only in IDLE.
- abort  in  1  synchronous: drop the current window and return to IDLE.
- vote_valid  in  1  a vote is presented.
- vote_ready  out  1  the block accepts a vote this cycle.
- vote_data  in  VOTE_W  signed vote, Q.FRAC_BITS.
- vote_last  in  1  marks the final vote of the current stage.
- busy  out  1  a window is in progress.
- res_valid  out  1  the result is held.
- res_ready  in  1  downstream consumes the result.
- res_face  out  1  1 = all stages passed; 0 = rejected.
- res_stage  out  STAGE_W  stage that rejected, or NUM_STAGES-1 on a face.
- cur_stage  out  STAGE_W  stage being evaluated; drives the upstream classifier fetch.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, accumulator=0.
  - vote_ready=0, busy=0, res_valid=0, res_face=0, res_stage=0, cur_stage=0.
- Arithmetic:
  - vote_data is sign-extended to ACC_W before adding.
  - Additions saturate at the signed ACC_W limits; they never wrap.
  - Pass condition: signed sum >= threshold[cur_stage].
- States:
  - IDLE: vote_ready=0. On start: clear the accumulator, set cur_stage=0 and busy=1, go to ACCUM.
  - ACCUM: vote_ready=1. Each cycle with vote_valid&vote_ready, add the vote. If vote_last is also set, go to CMP; vote_ready drops the next cycle. The ROM read of threshold[cur_stage] is registered and issued on entry to ACCUM, so it is ready by CMP.
  - CMP (one cycle):
    - Fail: res_face=0, res_stage=cur_stage, go to DONE.
    - Pass with cur_stage==NUM_STAGES-1: res_face=1, res_stage=cur_stage, go to DONE.
    - Pass otherwise: cur_stage+1, clear the accumulator, return to ACCUM.
  - DONE: res_valid=1 and result outputs stay stable until res_ready. On res_ready: res_valid=0, busy=0, go to IDLE.
- Latency: the stage decision is made in the cycle after the vote_last handshake; res_valid rises one cycle after CMP.
- Minimum gap between stages: one idle cycle (CMP) between vote_last and the next accepted vote.
- Boundary conditions:
  - A single-vote stage (vote_last on the first vote) is legal.
  - start in any state other than IDLE is ignored.
  - abort has priority over every other event in the same cycle. From any state it goes to IDLE, clears the accumulator and cur_stage, and sets busy=0, res_valid=0.
  - start together with abort in IDLE: abort wins and the block stays in IDLE.
  - vote_valid outside ACCUM is not accepted and is not added.
  - Reset asserted mid-window returns every output to its reset value immediately.

Decomposition:
- Package cascade_pkg holds:
  - FRAC_BITS and MAX_STAGES=64.
  - State enum typedef stage_state_t {IDLE, ACCUM, CMP, DONE}.
  - Constant array STAGE_THRESH_Q[MAX_STAGES] of signed ACC_W values: the 22 trained thresholds rounded to nearest at Q.12 (e.g. stage0 = 3370, stage1 = 28494, stage21 = 433197); unused entries = 0.
- Sub-module stage_thresh_rom:
  - Registered read of STAGE_THRESH_Q indexed by stage.
  - Parameterised on NUM_STAGES and ACC_W.
  - Replaces the current combinational real-valued lookup.

Test Plan:
- Stage-0 reject: start; votes 1000, 2000, last=1 (sum 3000 < 3370) -> res_valid with res_face=0, res_stage=0, 2 cycles after last; busy drops after res_ready.
- Exact-threshold pass: stage0 votes summing to exactly 3370 -> advances, cur_stage=1, accumulator cleared; stage1 sum 28493 -> reject at res_stage=1.
- Full pass, NUM_STAGES=2: stage0 sum 4000, stage1 sum 30000 -> res_face=1, res_stage=1; holding res_ready=0 for 5 cycles keeps the outputs stable.
- Saturation: ACC_W=16, FRAC_BITS=4; votes +32767, +32767 -> sum clamps to 32767 with no wrap, so the stage passes; negative votes clamp at -32768.
- Abort/priority: abort mid-stage-3 together with vote_valid -> vote not added, IDLE next cycle, busy=0; a later start restarts at stage 0 with sum 0.
- Handshake gaps: vote_valid toggles randomly, res_ready is delayed; start is asserted during DONE -> ignored, the result is unchanged, and the count of accepted votes equals the number of valid&ready cycles.
